dma_ctrl: RTL and testbench

Memory-to-memory DMA engine that sits beside the MIPS core as a bus master on the data-memory port. The CPU programs it through MTC2-style register writes. It requests the bus by driving `hold` into `maindec` and waits for `holdACK`, which makes it the requesting end of the core's hold/holdACK handshake. It then copies a block of words in `dmem` and returns the bus, raising a one-cycle interrupt.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_ctrl.sv | 129 ++++++++++++
 tb/tb_dma_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA register map and FSM state encoding.
// Imported by dma_ctrl.
package dma_pkg;

  localparam logic [4:0] DMA_SRC  = 5'b11000;
  localparam logic [4:0] DMA_DST  = 5'b11001;
  localparam logic [4:0] DMA_LEN  = 5'b11010;
  localparam logic [4:0] DMA_CTRL = 5'b11011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD,
    ST_WR,
    ST_DONE
  } dma_state_e;

endpackage

// File: rtl/dma_ctrl.sv
// dma_ctrl: mem-to-mem DMA master on the dmem port (hold/holdACK).
// Ports: clk, rst(async low), we/addr/dataIn/rd_data regs, hold/holdACK, dm_*, busy/done/irq.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int wide = 32,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [wide-1:0] dataIn,
  output logic [wide-1:0] rd_data,
  output logic            hold,
  input  logic            holdACK,
  output logic [wide-1:0] dm_addr,
  output logic [wide-1:0] dm_d,
  output logic            dm_we,
  input  logic [wide-1:0] dm_q,
  output logic            busy,
  output logic            done,
  output logic            irq
);

  dma_state_e      state;
  logic [wide-1:0] src;
  logic [wide-1:0] dst;
  logic [LENW-1:0] len;
  logic [wide-1:0] wbuf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      src   <= '0;
      dst   <= '0;
      len   <= '0;
      wbuf  <= '0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (we) begin
            case (addr)
              DMA_SRC: src <= {dataIn[wide-1:2], 2'b00};
              DMA_DST: dst <= {dataIn[wide-1:2], 2'b00};
              DMA_LEN: len <= dataIn[LENW-1:0];
              DMA_CTRL: begin
                // start beats clear; both end with done low
                if (dataIn[0]) begin
                  done  <= 1'b0;
                  state <= (len == '0) ? ST_DONE : ST_REQ;
                end else if (dataIn[1]) begin
                  done <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        ST_REQ: begin
          if (holdACK) state <= ST_RD;
        end
        ST_RD: begin
          if (holdACK) begin
            wbuf  <= dm_q;
            state <= ST_WR;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_WR: begin
          // lost grant: nothing committed, word is re-read
          if (holdACK) begin
            src   <= src + wide'(4);
            dst   <= dst + wide'(4);
            len   <= len - LENW'(1);
            state <= (len == LENW'(1)) ? ST_DONE : ST_RD;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // decoded from state so reset drops them asynchronously
  always_comb begin
    hold    = 1'b0;
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_d    = '0;
    irq     = 1'b0;
    unique case (state)
      ST_REQ: hold = 1'b1;
      ST_RD: begin
        hold    = 1'b1;
        dm_addr = src;
      end
      ST_WR: begin
        hold    = 1'b1;
        dm_addr = dst;
        dm_d    = wbuf;
        dm_we   = holdACK;
      end
      ST_DONE: irq = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_comb begin
    rd_data = '0;
    case (addr)
      DMA_SRC:  rd_data = src;
      DMA_DST:  rd_data = dst;
      DMA_LEN:  rd_data = {{(wide-LENW){1'b0}}, len};
      DMA_CTRL: rd_data = {{(wide-2){1'b0}}, done, busy};
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: scoreboard bench for dma_ctrl with a word-level copy model.
// Drives register writes, grant patterns and a behavioural dmem.
module tb_dma_ctrl;

  localparam logic [4:0] A_SRC  = 5'b11000;
  localparam logic [4:0] A_DST  = 5'b11001;
  localparam logic [4:0] A_LEN  = 5'b11010;
  localparam logic [4:0] A_CTRL = 5'b11011;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] dataIn;
  logic [31:0] rd_data;
  logic        hold;
  logic        holdACK;
  logic [31:0] dm_addr;
  logic [31:0] dm_d;
  logic        dm_we;
  logic [31:0] dm_q;
  logic        busy;
  logic        done;
  logic        irq;
  logic        grant_en;

  dma_ctrl #(.wide(32), .LENW(16)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .dataIn(dataIn),
    .rd_data(rd_data), .hold(hold), .holdACK(holdACK),
    .dm_addr(dm_addr), .dm_d(dm_d), .dm_we(dm_we), .dm_q(dm_q),
    .busy(busy), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  assign holdACK = hold & grant_en;

  logic [31:0] mem [1024];
  logic [31:0] mdl [1024];

  assign dm_q = mem[dm_addr[11:2]];

  always @(posedge clk) if (dm_we) mem[dm_addr[11:2]] = dm_d;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] rd_log[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int irq_cnt = 0;
  int irq_cyc = 0;
  int wr_cnt = 0;
  int irq_base, wr_base, start_cyc;
  bit hold_seen;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // monitor: pops expected writes whenever the DUT writes
  always @(negedge clk) begin
    if (rst) begin
      if (irq) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
      if (hold) hold_seen = 1'b1;
      if (hold && !dm_we) rd_log.push_back(dm_addr);
      if (dm_we) begin
        wr_t e;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", dm_addr, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", dm_addr, e.a);
          chk("wr_data", dm_d, e.d);
        end
      end
    end
  end

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    dataIn = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rd_data;
  endtask

  // reference: forward word-by-word copy over a flat word array
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic [31:0] ctrl);
    for (int i = 0; i < n; i++) begin
      logic [31:0] sa, da, w;
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      w  = mdl[sa[11:2]];
      mdl[da[11:2]] = w;
      exp_q.push_back('{da, w});
    end
    wr_reg(A_SRC, s);
    wr_reg(A_DST, d);
    wr_reg(A_LEN, 32'(n));
    rd_log.delete();
    hold_seen = 1'b0;
    wr_base = wr_cnt;
    irq_base = irq_cnt;
    wr_reg(A_CTRL, ctrl);
    start_cyc = cyc;
  endtask

  task automatic finish_copy(input int n, input bit timed);
    int k;
    int bad;
    logic [31:0] v;
    k = 0;
    while (irq_cnt == irq_base && k < 200 + 50 * n) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("irq_count", 32'(irq_cnt - irq_base), 32'd1);
    if (timed)
      chk("irq_time", 32'(irq_cyc - start_cyc),
          (n == 0) ? 32'd0 : 32'(2 * n + 1));
    chk("write_count", 32'(wr_cnt - wr_base), 32'(n));
    chk("pending", 32'(exp_q.size()), 32'd0);
    rd_reg(A_CTRL, v);
    chk("status", v, 32'h2);
    rd_reg(A_LEN, v);
    chk("len_left", v, 32'h0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== mdl[i]) bad++;
    chk("mem_words_bad", 32'(bad), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int k, n404;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      mdl[i] = mem[i];
    end
    rst = 1'b0;
    we = 1'b0;
    addr = 5'd0;
    dataIn = 32'd0;
    grant_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold", {31'b0, hold}, 32'd0);
    chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_d", dm_d, 32'd0);
    chk("rst_flags", {29'b0, busy, done, irq}, 32'd0);
    rd_reg(A_SRC, v);
    chk("rst_src", v, 32'd0);
    rd_reg(A_LEN, v);
    chk("rst_len", v, 32'd0);
    rd_reg(5'd3, v);
    chk("unmapped", v, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // basic copy, continuous grant
    start_copy(32'h100, 32'h200, 4, 32'h1);
    finish_copy(4, 1'b1);
    chk("basic_rd_n", 32'(rd_log.size()), 32'd5);

    // zero length: no bus request
    start_copy(32'h40, 32'h80, 0, 32'h1);
    finish_copy(0, 1'b1);
    chk("zero_hold", {31'b0, hold_seen}, 32'd0);

    // clear done
    wr_reg(A_CTRL, 32'h2);
    rd_reg(A_CTRL, v);
    chk("clear_done", v, 32'h0);

    // start + clear together
    start_copy(32'h40, 32'h80, 0, 32'h1);
    finish_copy(0, 1'b1);
    start_copy(32'h600, 32'h700, 2, 32'h3);
    rd_reg(A_CTRL, v);
    chk("start_clear", v, 32'h1);
    finish_copy(2, 1'b1);

    // delayed grant
    grant_en = 1'b0;
    start_copy(32'h100, 32'h800, 3, 32'h1);
    for (int i = 0; i < 10; i++) begin
      chk("nogrant_we", {31'b0, dm_we}, 32'd0);
      chk("nogrant_addr", dm_addr, 32'd0);
      @(negedge clk);
    end
    grant_en = 1'b1;
    finish_copy(3, 1'b0);

    // overlapping forward copy with random length
    k = $urandom_range(2, 6);
    start_copy(32'h900, 32'h904, k, 32'h1);
    finish_copy(k, 1'b1);

    // grant drop during WR of word 2
    start_copy(32'h400, 32'h500, 3, 32'h1);
    k = 0;
    while (!(hold && dm_addr == 32'h404) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("found_rd2", {31'b0, k < 50}, 32'd1);
    @(posedge clk);
    #1 grant_en = 1'b0;
    @(negedge clk);
    chk("drop_we", {31'b0, dm_we}, 32'd0);
    chk("drop_addr", dm_addr, 32'h504);
    repeat (2) @(negedge clk);
    grant_en = 1'b1;
    finish_copy(3, 1'b0);
    n404 = 0;
    foreach (rd_log[i]) if (rd_log[i] == 32'h404) n404++;
    chk("reread_w2", 32'(n404), 32'd2);

    // address wrap
    start_copy(32'hFFFFFFFC, 32'hA00, 2, 32'h1);
    finish_copy(2, 1'b1);
    chk("wrap_rd_n", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() >= 3) begin
      chk("wrap_rd1", rd_log[1], 32'hFFFFFFFC);
      chk("wrap_rd2", rd_log[2], 32'h0);
    end

    // busy protection
    start_copy(32'hB00, 32'hC00, 6, 32'h1);
    repeat (2) @(negedge clk);
    wr_reg(A_SRC, 32'hFFF0);
    wr_reg(A_CTRL, 32'h1);
    finish_copy(6, 1'b1);
    rd_reg(A_SRC, v);
    chk("busy_src", v, 32'hB18);
    rd_reg(A_DST, v);
    chk("busy_dst", v, 32'hC18);

    // abort by reset mid-transfer
    start_copy(32'hD00, 32'hE00, 8, 32'h1);
    repeat (5) @(negedge clk);
    chk("pre_abort_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_hold", {31'b0, hold}, 32'd0);
    chk("abort_we", {31'b0, dm_we}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    rd_reg(A_SRC, v);
    chk("abort_src", v, 32'd0);
    rd_reg(A_DST, v);
    chk("abort_dst", v, 32'd0);
    rd_reg(A_LEN, v);
    chk("abort_len", v, 32'd0);
    rd_reg(A_CTRL, v);
    chk("abort_status", v, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
